ahb_dma_csr_bank: RTL and testbench
===================================

Name: ahb_dma_csr_bank

Overview:
Parametrised register bank for the next-generation AHB DMA. Holds global control/IRQ registers and per-channel CTRL/TXSZ/ADR0/ADR1/INTEN/INTSTAT registers for up to 31 channels. Sits between the AHB slave decode and the DMA engine. Adds to the previous generation:
- per-channel W1C interrupt status with separate done/error causes;
- engine write-back priority;
- configurable transfer-size width.

Parameters:
CH_NUM, 4, number of channels, 1..31
TXSZ_W, 12, transfer-size field width, 1..32
CH_SEL_W, $clog2(CH_NUM>1?CH_NUM:2), width of ch_sel
VERSION, 32'h0002_0000, value returned by global VERSION register

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ahb_address  in  8  write word address
ahb_write_data  in  32  write data
ahb_write_enable  in  1  write strobe, one cycle per write
ahb_read_address  in  8  read word address
ahb_read_enable  in  1  read strobe
ahb_read_data  out  32  registered read data
irq_o  out  1  registered interrupt request
pause_req  out  1  CSR.pause to engine
paused  in  1  engine pause acknowledge
dma_busy  in  1  engine busy status
ch_sel  in  CH_SEL_W  channel the engine is serving
dma_done  in  1  one-cycle done pulse for ch_sel
dma_err  in  1  one-cycle error pulse for ch_sel
de_txsz_we / de_adr0_we / de_adr1_we  in  1 each  engine write-back strobes
de_txsz  in  TXSZ_W  engine TXSZ value
de_adr0 / de_adr1  in  32 each  engine address values
ch_en  out  CH_NUM  per-channel CTRL.enable
ch_ctrl  out  CH_NUM*32  packed CTRL registers, channel k at [32k+:32]
ch_txsz  out  CH_NUM*TXSZ_W  packed TXSZ
ch_adr0 / ch_adr1  out  CH_NUM*32 each  packed addresses

Behaviour:
- Reset: every register and output is 0, including ahb_read_data and irq_o.
- Address decode: addr[7:3]=0 selects the global block; addr[7:3]=k (1..CH_NUM) selects channel k-1; addr[2:0] selects the register.
- Any other block, and any reserved offset, reads 0 and ignores writes.
- Global registers:
  - 0 CSR: bit0 pause (RW), bit1 paused (RO), bit2 dma_busy (RO).
  - 1 IRQ_MASK[CH_NUM-1:0]: RW.
  - 2 IRQ_SRC: RO, equals mask & ch_irq.
  - 3 IRQ_RAW: RO, equals ch_irq.
  - 4 VERSION: RO.
- Channel registers:
  - 0 CTRL: RW, 32 bits; bit0 = enable.
  - 1 TXSZ: RW, [TXSZ_W-1:0]; upper bits read 0.
  - 2 ADR0: RW.
  - 3 ADR1: RW.
  - 4 INTEN: RW; bit0 done, bit1 err.
  - 5 INTSTAT: bit0 done, bit1 err; writing 1 clears a bit, writing 0 has no effect.
  - 6 DONE_CNT: optional, see below.
  - 7: reserved, reads 0.
- Read timing: ahb_read_data is valid the cycle after ahb_read_enable. It is 0 in any cycle following a cycle with read_enable low.
- Writes: take effect at the clock edge where write_enable is high; readback is visible in the next read.
- Engine write-back: de_*_we updates channel ch_sel. If a bus write and an engine write hit the same register in the same cycle, the engine wins.
- On dma_done for ch_sel:
  - set INTSTAT.done;
  - clear CTRL.enable. The clear beats a simultaneous bus write of enable=1.
- On dma_err for ch_sel: set INTSTAT.err and clear CTRL.enable.
- If a set event and a W1C hit the same INTSTAT bit in the same cycle, the set wins.
- ch_sel values at or above CH_NUM: engine inputs are ignored.
- ch_irq[k] = |(INTSTAT[k][1:0] & INTEN[k][1:0]).
- irq_o is registered: it asserts one cycle after IRQ_SRC becomes nonzero and drops one cycle after it becomes zero.
- Pause: pause_req = CSR.pause combinationally from the flop. paused is reflected live in the readback.
- Reset mid-operation: all state clears immediately (async); no pending interrupt survives.

Optional Feature:
- Macro: AHB_DMA_CSR_DONE_CNT_EN.
- When defined:
  - channel offset 6 is a 16-bit DONE_CNT, incremented on each dma_done for that channel;
  - it saturates at 16'hFFFF;
  - any bus write to it clears it to 0;
  - if a write and a done occur in the same cycle, the result is 1.
- When undefined: no counter flops exist; offset 6 reads 0 and ignores writes.

Decomposition:
- Package ahb_dma_csr_pkg holds:
  - register offset localparams (CSR, IRQ_MASK, IRQ_SRC, IRQ_RAW, VERSION, CTRL, TXSZ, ADR0, ADR1, INTEN, INTSTAT, DONE_CNT);
  - INTSTAT bit-index constants;
  - the VERSION default.
- One sub-module, ahb_dma_csr_ch, is instantiated CH_NUM times by generate. It contains one channel's registers, its priority logic and its ch_irq output.
- The top level holds the global registers, read mux and irq_o flop.

Test Plan:
- Reset, then read all global offsets and channel 0 offsets 0..7 → all 0 except VERSION = 32'h0002_0000; irq_o = 0.
- Write CH1 ADR0 = 32'hDEAD_BEEF (addr 8'h12), read it back → 32'hDEAD_BEEF one cycle after read_enable. Read addr 8'h28 with CH_NUM=4 → 0.
- In one cycle, bus writes CH0 TXSZ = 12'h100 while de_txsz_we=1, ch_sel=0, de_txsz=12'h0FF → TXSZ reads 12'h0FF.
- Set INTEN[2]=3 and IRQ_MASK=4'b0100, then pulse dma_done with ch_sel=2 → INTSTAT[2]=1, CTRL[2].enable=0, IRQ_SRC=4, irq_o high the next cycle. Write INTSTAT=1 → irq_o low two cycles later.
- Same cycle: W1C INTSTAT.err on CH3 and dma_err with ch_sel=3 → err stays 1. Write CSR=1 → pause_req=1; drive paused=1 → CSR reads 3.
- With AHB_DMA_CSR_DONE_CNT_EN defined: 3 dma_done pulses on CH0 → DONE_CNT=3; write it while a done occurs → 1. Without the macro: offset 6 reads 0.

Source files
------------

// File: rtl/ahb_dma_csr_pkg.sv
// Shared constants for the AHB DMA CSR bank: register offsets, INTSTAT bit
// indices and the default VERSION value.
package ahb_dma_csr_pkg;

    localparam logic [2:0] CSR_OFF      = 3'd0;
    localparam logic [2:0] IRQ_MASK_OFF = 3'd1;
    localparam logic [2:0] IRQ_SRC_OFF  = 3'd2;
    localparam logic [2:0] IRQ_RAW_OFF  = 3'd3;
    localparam logic [2:0] VERSION_OFF  = 3'd4;

    localparam logic [2:0] CTRL_OFF     = 3'd0;
    localparam logic [2:0] TXSZ_OFF     = 3'd1;
    localparam logic [2:0] ADR0_OFF     = 3'd2;
    localparam logic [2:0] ADR1_OFF     = 3'd3;
    localparam logic [2:0] INTEN_OFF    = 3'd4;
    localparam logic [2:0] INTSTAT_OFF  = 3'd5;
    localparam logic [2:0] DONE_CNT_OFF = 3'd6;

    localparam int unsigned INT_DONE_BIT = 0;
    localparam int unsigned INT_ERR_BIT  = 1;

    localparam logic [31:0] VERSION_DEFAULT = 32'h0002_0000;

endpackage

// File: rtl/ahb_dma_csr_ch.sv
// One DMA channel's register set with bus/engine priority and its irq cause.
// Optional DONE_CNT counter is built only when AHB_DMA_CSR_DONE_CNT_EN is defined.
module ahb_dma_csr_ch
    import ahb_dma_csr_pkg::*;
#(
    parameter int unsigned TXSZ_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [2:0]        wr_off_i,
    input  logic [31:0]       wr_data_i,
    input  logic              eng_sel_i,
    input  logic              dma_done_i,
    input  logic              dma_err_i,
    input  logic              de_txsz_we_i,
    input  logic              de_adr0_we_i,
    input  logic              de_adr1_we_i,
    input  logic [TXSZ_W-1:0] de_txsz_i,
    input  logic [31:0]       de_adr0_i,
    input  logic [31:0]       de_adr1_i,
    output logic [31:0]       ctrl_o,
    output logic [TXSZ_W-1:0] txsz_o,
    output logic [31:0]       adr0_o,
    output logic [31:0]       adr1_o,
    output logic [1:0]        inten_o,
    output logic [1:0]        intstat_o,
    output logic [15:0]       done_cnt_o,
    output logic              ch_irq_o
);

    logic [31:0]       ctrl_q, ctrl_d;
    logic [TXSZ_W-1:0] txsz_q, txsz_d;
    logic [31:0]       adr0_q, adr0_d;
    logic [31:0]       adr1_q, adr1_d;
    logic [1:0]        inten_q, inten_d;
    logic [1:0]        intstat_q, intstat_d;

    // Bus write first, engine events afterwards so they take priority.
    always_comb begin
        ctrl_d    = ctrl_q;
        txsz_d    = txsz_q;
        adr0_d    = adr0_q;
        adr1_d    = adr1_q;
        inten_d   = inten_q;
        intstat_d = intstat_q;
        if (wr_en_i) begin
            case (wr_off_i)
                CTRL_OFF:    ctrl_d    = wr_data_i;
                TXSZ_OFF:    txsz_d    = wr_data_i[TXSZ_W-1:0];
                ADR0_OFF:    adr0_d    = wr_data_i;
                ADR1_OFF:    adr1_d    = wr_data_i;
                INTEN_OFF:   inten_d   = wr_data_i[1:0];
                INTSTAT_OFF: intstat_d = intstat_q & ~wr_data_i[1:0];
                default: ;
            endcase
        end
        if (eng_sel_i) begin
            if (de_txsz_we_i) txsz_d = de_txsz_i;
            if (de_adr0_we_i) adr0_d = de_adr0_i;
            if (de_adr1_we_i) adr1_d = de_adr1_i;
            if (dma_done_i) begin
                intstat_d[INT_DONE_BIT] = 1'b1;
                ctrl_d[0]               = 1'b0;
            end
            if (dma_err_i) begin
                intstat_d[INT_ERR_BIT] = 1'b1;
                ctrl_d[0]              = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q    <= '0;
            txsz_q    <= '0;
            adr0_q    <= '0;
            adr1_q    <= '0;
            inten_q   <= '0;
            intstat_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            txsz_q    <= txsz_d;
            adr0_q    <= adr0_d;
            adr1_q    <= adr1_d;
            inten_q   <= inten_d;
            intstat_q <= intstat_d;
        end
    end

`ifdef AHB_DMA_CSR_DONE_CNT_EN
    logic [15:0] done_cnt_q, done_cnt_d;
    logic        cnt_wr;

    // A write clears; a coincident done then counts as the first event.
    always_comb begin
        cnt_wr     = wr_en_i && (wr_off_i == DONE_CNT_OFF);
        done_cnt_d = done_cnt_q;
        if (cnt_wr) done_cnt_d = '0;
        if (eng_sel_i && dma_done_i) begin
            if (cnt_wr)                       done_cnt_d = 16'd1;
            else if (done_cnt_q != 16'hFFFF)  done_cnt_d = done_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) done_cnt_q <= '0;
        else         done_cnt_q <= done_cnt_d;
    end

    assign done_cnt_o = done_cnt_q;
`else
    assign done_cnt_o = '0;
`endif

    assign ctrl_o    = ctrl_q;
    assign txsz_o    = txsz_q;
    assign adr0_o    = adr0_q;
    assign adr1_o    = adr1_q;
    assign inten_o   = inten_q;
    assign intstat_o = intstat_q;
    assign ch_irq_o  = |(intstat_q & inten_q);

endmodule

// File: rtl/ahb_dma_csr_bank.sv
// AHB DMA CSR bank top: global CSR/IRQ registers, read mux, irq_o flop and
// CH_NUM channel instances. Optional DONE_CNT: define AHB_DMA_CSR_DONE_CNT_EN.
module ahb_dma_csr_bank
    import ahb_dma_csr_pkg::*;
#(
    parameter int unsigned CH_NUM   = 4,
    parameter int unsigned TXSZ_W   = 12,
    parameter int unsigned CH_SEL_W = $clog2(CH_NUM > 1 ? CH_NUM : 2),
    parameter logic [31:0] VERSION  = VERSION_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               ahb_address,
    input  logic [31:0]              ahb_write_data,
    input  logic                     ahb_write_enable,
    input  logic [7:0]               ahb_read_address,
    input  logic                     ahb_read_enable,
    output logic [31:0]              ahb_read_data,
    output logic                     irq_o,
    output logic                     pause_req,
    input  logic                     paused,
    input  logic                     dma_busy,
    input  logic [CH_SEL_W-1:0]      ch_sel,
    input  logic                     dma_done,
    input  logic                     dma_err,
    input  logic                     de_txsz_we,
    input  logic                     de_adr0_we,
    input  logic                     de_adr1_we,
    input  logic [TXSZ_W-1:0]        de_txsz,
    input  logic [31:0]              de_adr0,
    input  logic [31:0]              de_adr1,
    output logic [CH_NUM-1:0]        ch_en,
    output logic [CH_NUM*32-1:0]     ch_ctrl,
    output logic [CH_NUM*TXSZ_W-1:0] ch_txsz,
    output logic [CH_NUM*32-1:0]     ch_adr0,
    output logic [CH_NUM*32-1:0]     ch_adr1
);

    logic [4:0]        wr_blk, rd_blk;
    logic [2:0]        wr_off, rd_off;
    logic              pause_q;
    logic [CH_NUM-1:0] irq_mask_q;
    logic [CH_NUM-1:0] ch_irq, irq_src;
    logic [31:0]       rdata_q, rdata_d;
    logic              irq_q;

    logic [31:0]       ctrl_a    [CH_NUM];
    logic [TXSZ_W-1:0] txsz_a    [CH_NUM];
    logic [31:0]       adr0_a    [CH_NUM];
    logic [31:0]       adr1_a    [CH_NUM];
    logic [1:0]        inten_a   [CH_NUM];
    logic [1:0]        intstat_a [CH_NUM];
    logic [15:0]       dcnt_a    [CH_NUM];

    assign wr_blk  = ahb_address[7:3];
    assign wr_off  = ahb_address[2:0];
    assign rd_blk  = ahb_read_address[7:3];
    assign rd_off  = ahb_read_address[2:0];
    assign irq_src = irq_mask_q & ch_irq;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        logic ch_wr, eng_sel;
        assign ch_wr   = ahb_write_enable && (wr_blk == 5'(k + 1));
        // Out-of-range ch_sel matches no instance, so engine inputs are dropped.
        assign eng_sel = (ch_sel == CH_SEL_W'(k));

        ahb_dma_csr_ch #(.TXSZ_W(TXSZ_W)) u_ch (
            .clk_i        (clk),
            .rst_ni       (rst),
            .wr_en_i      (ch_wr),
            .wr_off_i     (wr_off),
            .wr_data_i    (ahb_write_data),
            .eng_sel_i    (eng_sel),
            .dma_done_i   (dma_done),
            .dma_err_i    (dma_err),
            .de_txsz_we_i (de_txsz_we),
            .de_adr0_we_i (de_adr0_we),
            .de_adr1_we_i (de_adr1_we),
            .de_txsz_i    (de_txsz),
            .de_adr0_i    (de_adr0),
            .de_adr1_i    (de_adr1),
            .ctrl_o       (ctrl_a[k]),
            .txsz_o       (txsz_a[k]),
            .adr0_o       (adr0_a[k]),
            .adr1_o       (adr1_a[k]),
            .inten_o      (inten_a[k]),
            .intstat_o    (intstat_a[k]),
            .done_cnt_o   (dcnt_a[k]),
            .ch_irq_o     (ch_irq[k])
        );

        assign ch_en[k]                    = ctrl_a[k][0];
        assign ch_ctrl[32*k +: 32]         = ctrl_a[k];
        assign ch_txsz[TXSZ_W*k +: TXSZ_W] = txsz_a[k];
        assign ch_adr0[32*k +: 32]         = adr0_a[k];
        assign ch_adr1[32*k +: 32]         = adr1_a[k];
    end

    always_comb begin
        rdata_d = '0;
        if (ahb_read_enable) begin
            if (rd_blk == 5'd0) begin
                case (rd_off)
                    CSR_OFF:      rdata_d = {29'd0, dma_busy, paused, pause_q};
                    IRQ_MASK_OFF: rdata_d = 32'(irq_mask_q);
                    IRQ_SRC_OFF:  rdata_d = 32'(irq_src);
                    IRQ_RAW_OFF:  rdata_d = 32'(ch_irq);
                    VERSION_OFF:  rdata_d = VERSION;
                    default: ;
                endcase
            end
            for (int unsigned k = 0; k < CH_NUM; k++) begin
                if (rd_blk == 5'(k + 1)) begin
                    case (rd_off)
                        CTRL_OFF:     rdata_d = ctrl_a[k];
                        TXSZ_OFF:     rdata_d = 32'(txsz_a[k]);
                        ADR0_OFF:     rdata_d = adr0_a[k];
                        ADR1_OFF:     rdata_d = adr1_a[k];
                        INTEN_OFF:    rdata_d = {30'd0, inten_a[k]};
                        INTSTAT_OFF:  rdata_d = {30'd0, intstat_a[k]};
                        DONE_CNT_OFF: rdata_d = {16'd0, dcnt_a[k]};
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pause_q    <= 1'b0;
            irq_mask_q <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (ahb_write_enable && (wr_blk == 5'd0)) begin
                case (wr_off)
                    CSR_OFF:      pause_q    <= ahb_write_data[0];
                    IRQ_MASK_OFF: irq_mask_q <= ahb_write_data[CH_NUM-1:0];
                    default: ;
                endcase
            end
            rdata_q <= rdata_d;
            irq_q   <= |irq_src;
        end
    end

    assign ahb_read_data = rdata_q;
    assign irq_o         = irq_q;
    assign pause_req     = pause_q;

endmodule

// File: tb/tb_ahb_dma_csr_bank.sv
// Scoreboard bench for ahb_dma_csr_bank: reads push expectations, a monitor
// pops them when the registered read data is presented.
module tb_ahb_dma_csr_bank;

    localparam int unsigned CH_NUM   = 4;
    localparam int unsigned TXSZ_W   = 12;
    localparam int unsigned CH_SEL_W = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [7:0]               ahb_address, ahb_read_address;
    logic [31:0]              ahb_write_data;
    logic                     ahb_write_enable, ahb_read_enable;
    logic [31:0]              ahb_read_data;
    logic                     irq_o, pause_req, paused, dma_busy;
    logic [CH_SEL_W-1:0]      ch_sel;
    logic                     dma_done, dma_err;
    logic                     de_txsz_we, de_adr0_we, de_adr1_we;
    logic [TXSZ_W-1:0]        de_txsz;
    logic [31:0]              de_adr0, de_adr1;
    logic [CH_NUM-1:0]        ch_en;
    logic [CH_NUM*32-1:0]     ch_ctrl, ch_adr0, ch_adr1;
    logic [CH_NUM*TXSZ_W-1:0] ch_txsz;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        rd_pend = 1'b0;

    always #5 clk = ~clk;

    ahb_dma_csr_bank #(
        .CH_NUM   (CH_NUM),
        .TXSZ_W   (TXSZ_W),
        .CH_SEL_W (CH_SEL_W),
        .VERSION  (32'h0002_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ahb_address      (ahb_address),
        .ahb_write_data   (ahb_write_data),
        .ahb_write_enable (ahb_write_enable),
        .ahb_read_address (ahb_read_address),
        .ahb_read_enable  (ahb_read_enable),
        .ahb_read_data    (ahb_read_data),
        .irq_o            (irq_o),
        .pause_req        (pause_req),
        .paused           (paused),
        .dma_busy         (dma_busy),
        .ch_sel           (ch_sel),
        .dma_done         (dma_done),
        .dma_err          (dma_err),
        .de_txsz_we       (de_txsz_we),
        .de_adr0_we       (de_adr0_we),
        .de_adr1_we       (de_adr1_we),
        .de_txsz          (de_txsz),
        .de_adr0          (de_adr0),
        .de_adr1          (de_adr1),
        .ch_en            (ch_en),
        .ch_ctrl          (ch_ctrl),
        .ch_txsz          (ch_txsz),
        .ch_adr0          (ch_adr0),
        .ch_adr1          (ch_adr1)
    );

    always @(posedge clk) rd_pend <= ahb_read_enable;

    // Read data is presented the cycle after a read strobe, else must be 0.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_underflow: got %h with no expected value", ahb_read_data);
            end else begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_chk++;
                if (ahb_read_data !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", nm, ahb_read_data, e);
                end
            end
        end else begin
            n_chk++;
            if (ahb_read_data !== 32'd0) begin
                n_fail++;
                $display("FAIL idle_zero: got %h expected 00000000", ahb_read_data);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        ahb_address      = a;
        ahb_write_data   = d;
        ahb_write_enable = 1'b1;
        @(negedge clk);
        ahb_write_enable = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        ahb_read_address = a;
        ahb_read_enable  = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        ahb_read_enable  = 1'b0;
    endtask

    task automatic pulse(input logic [1:0] sel, input logic done, input logic err);
        ch_sel   = sel;
        dma_done = done;
        dma_err  = err;
        @(negedge clk);
        dma_done = 1'b0;
        dma_err  = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        ahb_address = '0; ahb_write_data = '0; ahb_write_enable = 1'b0;
        ahb_read_address = '0; ahb_read_enable = 1'b0;
        paused = 1'b0; dma_busy = 1'b0; ch_sel = '0;
        dma_done = 1'b0; dma_err = 1'b0;
        de_txsz_we = 1'b0; de_adr0_we = 1'b0; de_adr1_we = 1'b0;
        de_txsz = '0; de_adr0 = '0; de_adr1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_pause", 32'(pause_req), 32'd0);
        chk("rst_ch_en", 32'(ch_en), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            logic [7:0] ga;
            ga = 8'(i);
            rd(ga, (i == 4) ? 32'h0002_0000 : 32'd0, $sformatf("rst_glob%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] ca;
            ca = 8'(8 + i);
            rd(ca, 32'd0, $sformatf("rst_ch0_off%0d", i));
        end

        wr(8'h12, 32'hDEAD_BEEF);
        rd(8'h12, 32'hDEAD_BEEF, "ch1_adr0");
        chk("ch1_adr0_port", ch_adr0[32 +: 32], 32'hDEAD_BEEF);
        wr(8'h28, 32'h1234_5678);
        rd(8'h28, 32'd0, "oob_block");
        wr(8'h17, 32'hFFFF_FFFF);
        rd(8'h17, 32'd0, "ch1_reserved");

        de_txsz_we = 1'b1; ch_sel = 2'd0; de_txsz = 12'h0FF;
        wr(8'h09, 32'h0000_0100);
        de_txsz_we = 1'b0;
        rd(8'h09, 32'h0000_00FF, "txsz_engine_wins");
        wr(8'h09, 32'hFFFF_FABC);
        rd(8'h09, 32'h0000_0ABC, "txsz_truncate");
        chk("ch0_txsz_port", 32'(ch_txsz[0 +: TXSZ_W]), 32'h0000_0ABC);

        de_adr1_we = 1'b1; ch_sel = 2'd3; de_adr1 = 32'h0BAD_F00D;
        @(negedge clk);
        de_adr1_we = 1'b0;
        rd(8'h23, 32'h0BAD_F00D, "ch3_adr1_engine");

        wr(8'h18, 32'h0000_00A5);
        chk("ch2_en_set", 32'(ch_en), 32'h4);
        wr(8'h1C, 32'd3);
        wr(8'h01, 32'd4);
        ahb_address = 8'h18; ahb_write_data = 32'h0000_00A5; ahb_write_enable = 1'b1;
        pulse(2'd2, 1'b1, 1'b0);
        ahb_write_enable = 1'b0;
        chk("irq_latency", 32'(irq_o), 32'd0);
        rd(8'h02, 32'd4, "irq_src");
        chk("irq_set", 32'(irq_o), 32'd1);
        rd(8'h03, 32'd4, "irq_raw");
        rd(8'h1D, 32'd1, "ch2_intstat_done");
        rd(8'h18, 32'h0000_00A4, "ch2_ctrl_done_clear");
        chk("ch2_en_clear", 32'(ch_en), 32'd0);
        wr(8'h1D, 32'd1);
        chk("irq_hold", 32'(irq_o), 32'd1);
        @(negedge clk);
        chk("irq_drop", 32'(irq_o), 32'd0);
        rd(8'h1D, 32'd0, "ch2_intstat_w1c");

        pulse(2'd3, 1'b0, 1'b1);
        ahb_address = 8'h25; ahb_write_data = 32'd2; ahb_write_enable = 1'b1;
        pulse(2'd3, 1'b0, 1'b1);
        ahb_write_enable = 1'b0;
        rd(8'h25, 32'd2, "ch3_err_set_wins");
        wr(8'h25, 32'd0);
        rd(8'h25, 32'd2, "ch3_w0_noeffect");
        wr(8'h25, 32'd2);
        rd(8'h25, 32'd0, "ch3_err_w1c");
        rd(8'h03, 32'd0, "irq_raw_clear");

        wr(8'h00, 32'd1);
        chk("pause_req", 32'(pause_req), 32'd1);
        paused = 1'b1;
        rd(8'h00, 32'd3, "csr_paused");
        dma_busy = 1'b1;
        rd(8'h00, 32'd7, "csr_busy");
        dma_busy = 1'b0;
        wr(8'h01, 32'hFFFF_FFFF);
        rd(8'h01, 32'h0000_000F, "irq_mask_width");

        repeat (3) pulse(2'd0, 1'b1, 1'b0);
`ifdef AHB_DMA_CSR_DONE_CNT_EN
        rd(8'h0E, 32'd3, "done_cnt_3");
        ahb_address = 8'h0E; ahb_write_data = 32'd0; ahb_write_enable = 1'b1;
        pulse(2'd0, 1'b1, 1'b0);
        ahb_write_enable = 1'b0;
        rd(8'h0E, 32'd1, "done_cnt_wr_and_done");
        wr(8'h0E, 32'd0);
        rd(8'h0E, 32'd0, "done_cnt_clear");
`else
        wr(8'h0E, 32'hFFFF_FFFF);
        rd(8'h0E, 32'd0, "done_cnt_absent");
`endif

        wr(8'h14, 32'd1);
        pulse(2'd1, 1'b1, 1'b0);
        @(negedge clk);
        chk("irq_before_reset", 32'(irq_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_irq", 32'(irq_o), 32'd0);
        chk("async_rst_pause", 32'(pause_req), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd(8'h15, 32'd0, "ch1_intstat_after_rst");
        rd(8'h12, 32'd0, "ch1_adr0_after_rst");

        for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_drain: %0d pending expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
